branch_predict_ctrl: RTL and testbench
======================================

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL provide one clock and a synchronous, active-low reset; no other clock or reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 if_valid  in  1  fetch stage holds a valid PC.
REQ-005 if_pc  in  32  fetch-stage PC; bits [5:2] index the history table.
REQ-006 ex_valid  in  1  execute stage holds a valid instruction.
REQ-007 ex_branch  in  1  execute instruction is a conditional branch.
REQ-008 ex_jump  in  1  execute instruction is an unconditional jump.
REQ-009 ex_taken  in  1  resolved branch outcome from the branch condition unit.
REQ-010 ex_pred_taken  in  1  prediction carried down the pipeline with this instruction.
REQ-011 ex_pc  in  32  execute-stage PC.
REQ-012 ex_target  in  32  computed branch/jump target.
REQ-013 pred_taken  out  1  fetch-stage prediction, combinational.
REQ-014 redirect  out  1  PC select override, registered.
REQ-015 redirect_pc  out  32  corrected next PC, registered.
REQ-016 flush_if_id  out  1  squash IF/ID register, registered.
REQ-017 flush_id_ex  out  1  squash ID/EX register, registered.
REQ-018 mispredict_cnt  out  16  saturating mispredict count.

Function
REQ-019 SHALL hold a 16-entry table of 2-bit saturating counters, indexed by PC[5:2].
REQ-020 pred_taken SHALL equal if_valid AND bit[1] of counter[if_pc[5:2]]; same-cycle update not bypassed (old value seen).
REQ-021 resolve event SHALL be ex_valid & (ex_branch | ex_jump) while state==IDLE; ignored in any other state (wrong path).
REQ-022 mispredict SHALL be: branch -> ex_taken != ex_pred_taken; jump -> ex_pred_taken==0; ex_jump has priority if both set.
REQ-023 on a branch resolve event, counter SHALL increment (taken) saturating at 3, or decrement (not taken) saturating at 0, at next edge; jumps SHALL NOT update the table.
REQ-024 FSM states SHALL be IDLE, REDIRECT, RECOVER.
REQ-025 IDLE -> REDIRECT on mispredict; otherwise stay IDLE.
REQ-026 REDIRECT -> RECOVER unconditionally; RECOVER -> IDLE unconditionally.
REQ-027 in REDIRECT: redirect=1, flush_if_id=1, flush_id_ex=1.
REQ-028 in RECOVER: flush_if_id=1 only (squashes fetch issued during redirect cycle); redirect=0, flush_id_ex=0.
REQ-029 in IDLE: redirect, flush_if_id, flush_id_ex SHALL all be 0.
REQ-030 redirect_pc SHALL be captured on the IDLE->REDIRECT edge: ex_target if (ex_jump | ex_taken), else ex_pc+4 (mod 2^32, wrap at 0xFFFFFFFC -> 0).
REQ-031 redirect_pc SHALL hold its value outside REDIRECT.
REQ-032 latency: mispredict seen in cycle t -> redirect high in cycle t+1 exactly one cycle; flush_if_id high t+1 and t+2.
REQ-033 mispredict_cnt SHALL increment by 1 per accepted mispredict, saturating at 0xFFFF.
REQ-034 correctly predicted resolve events SHALL cause no redirect/flush.

Reset
REQ-035 when rst_n==0 at a rising edge: state=IDLE, all counters=2'b01, redirect_pc=0, mispredict_cnt=0, redirect/flush outputs 0 in the following cycle.
REQ-036 reset asserted in REDIRECT or RECOVER SHALL abort the sequence; no further flush pulse after reset.
REQ-037 reset SHALL override a coincident resolve event (no table or counter update).

Verification
REQ-038 after reset, if_valid=1, if_pc=0x40 -> pred_taken=0; branch ex_pc=0x40 taken twice (pred 0) -> second accepted only after FSM returns to IDLE; then pred_taken=1 for 0x40.
REQ-039 branch ex_pc=0x100, ex_target=0x80, ex_taken=1, ex_pred_taken=0 in cycle t -> redirect=1, redirect_pc=0x80 in t+1 only; flush_if_id t+1,t+2; flush_id_ex t+1 only; mispredict_cnt=1.
REQ-040 branch ex_pc=0xFFFFFFFC, ex_taken=0, ex_pred_taken=1 -> redirect_pc=0x00000000.
REQ-041 jump with ex_pred_taken=0 -> redirect to ex_target, table unchanged; jump with ex_pred_taken=1 -> no redirect.
REQ-042 mispredicting resolve events in REDIRECT and RECOVER cycles -> ignored: no counter update, cnt unchanged, FSM returns to IDLE on schedule.
REQ-043 force mispredict_cnt to 0xFFFF via 65535 mispredicts, one more -> stays 0xFFFF; rst_n=0 during REDIRECT -> next cycle all outputs 0, cnt=0.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// -----------------------------------------------------------------------------
// branch_predict_ctrl
// Branch predictor and mispredict recovery controller. Keeps a 16-entry table of
// 2-bit saturating counters for fetch-stage prediction. It resolves branches and
// jumps in execute, and on a mispredict it sequences the pipeline redirect and
// flush pulses.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   if_valid/if_pc  fetch-stage PC to predict (table index = if_pc[5:2])
//   ex_*            execute-stage resolution: valid, branch/jump type,
//                   resolved outcome, carried prediction, PC, target
//   pred_taken      combinational fetch prediction
//   redirect        registered PC-select override (one cycle)
//   redirect_pc     registered corrected PC, held between mispredicts
//   flush_if_id     registered IF/ID squash (two cycles)
//   flush_id_ex     registered ID/EX squash (one cycle)
//   mispredict_cnt  saturating count of accepted mispredicts
// -----------------------------------------------------------------------------
module branch_predict_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    output logic             pred_taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned PC_W    = 32;

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(3);
    localparam logic [CTR_W-1:0] CTR_MIN  = CTR_W'(0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        RECOVER  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CTR_W-1:0]    ctr_q [ENTRIES];
    logic [CTR_W-1:0]    ctr_d [ENTRIES];
    logic                redirect_q, redirect_d;
    logic                flush_if_id_q, flush_if_id_d;
    logic                flush_id_ex_q, flush_id_ex_d;
    logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]    if_idx;
    logic [IDX_W-1:0]    ex_idx;
    logic                resolve_c;
    logic                mispredict_c;
    logic                unused_if_pc_bits;

    assign if_idx = if_pc[5:2];
    assign ex_idx = ex_pc[5:2];
    assign unused_if_pc_bits = ^{if_pc[31:6], if_pc[1:0]};

    // Prediction reads the registered table, so a same-cycle update is not seen.
    assign pred_taken = if_valid & ctr_q[if_idx][1];

    // Only IDLE accepts resolutions; anything in execute during recovery is wrong-path.
    always_comb begin
        resolve_c    = ex_valid & (ex_branch | ex_jump) & (state_q == IDLE);
        mispredict_c = 1'b0;
        if (resolve_c) begin
            if (ex_jump) begin
                mispredict_c = ~ex_pred_taken;
            end else begin
                mispredict_c = ex_taken ^ ex_pred_taken;
            end
        end
    end

    // Next-state, table, capture and output logic.
    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        redirect_d    = 1'b0;
        flush_if_id_d = 1'b0;
        flush_id_ex_d = 1'b0;

        unique case (state_q)
            IDLE:     if (mispredict_c) state_d = REDIRECT;
            REDIRECT: state_d = RECOVER;
            RECOVER:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Jumps take priority over the branch flag and never train the table.
        if (resolve_c && !ex_jump) begin
            if (ex_taken) begin
                if (ctr_q[ex_idx] != CTR_MAX) ctr_d[ex_idx] = ctr_q[ex_idx] + CTR_W'(1);
            end else begin
                if (ctr_q[ex_idx] != CTR_MIN) ctr_d[ex_idx] = ctr_q[ex_idx] - CTR_W'(1);
            end
        end

        if (mispredict_c) begin
            redirect_pc_d = (ex_jump | ex_taken) ? ex_target : ex_pc + PC_W'(4);
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end

        // Outputs are registered from the next state so they align with it.
        redirect_d    = (state_d == REDIRECT);
        flush_if_id_d = (state_d != IDLE);
        flush_id_ex_d = (state_d == REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ctr_q         <= '{default: CTR_INIT};
            redirect_q    <= 1'b0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            redirect_q    <= redirect_d;
            flush_if_id_q <= flush_if_id_d;
            flush_id_ex_q <= flush_id_ex_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_if_id_q;
    assign flush_id_ex    = flush_id_ex_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_ctrl
// Self-checking bench for branch_predict_ctrl. It runs a directed vector table,
// hand-written reset/ignore sequences and randomized traffic against a
// behavioural model. A second instance with a 4-bit counter exercises
// mispredict-count saturation within a short run.
// -----------------------------------------------------------------------------
module tb_branch_predict_ctrl;

    typedef struct {
        logic        rst_n;
        logic        if_valid;
        logic [31:0] if_pc;
        logic        ex_valid;
        logic        ex_branch;
        logic        ex_jump;
        logic        ex_taken;
        logic        ex_pred_taken;
        logic [31:0] ex_pc;
        logic [31:0] ex_target;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        pred;
        logic        redir;
        logic [31:0] rpc;
        logic        fif;
        logic        fie;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;

    logic        pred_taken, redirect, flush_if_id, flush_id_ex;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    logic        unused_sat_pred, unused_sat_redirect, unused_sat_fif, unused_sat_fie;
    logic [31:0] unused_sat_rpc;
    logic [3:0]  sat_cnt;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
        .ex_target(ex_target), .pred_taken(pred_taken), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .mispredict_cnt(mispredict_cnt)
    );

    branch_predict_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
        .ex_target(ex_target), .pred_taken(unused_sat_pred),
        .redirect(unused_sat_redirect), .redirect_pc(unused_sat_rpc),
        .flush_if_id(unused_sat_fif), .flush_id_ex(unused_sat_fie),
        .mispredict_cnt(sat_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural reference: counter values 0..3, cycles left in the recovery
    // sequence (2 = redirect cycle, 1 = recover cycle), unbounded mispredict tally.
    int          m_tbl [16];
    int          m_busy;
    logic [31:0] m_rpc;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic stim_t st(input logic v, input logic b, input logic j,
                                 input logic t, input logic p,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic ifv, input logic [31:0] ifpc);
        stim_t r;
        r.rst_n = 1'b1; r.if_valid = ifv; r.if_pc = ifpc;
        r.ex_valid = v; r.ex_branch = b; r.ex_jump = j; r.ex_taken = t;
        r.ex_pred_taken = p; r.ex_pc = pc; r.ex_target = tgt;
        return r;
    endfunction

    function automatic stim_t idle_s(input logic ifv, input logic [31:0] ifpc);
        return st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ifv, ifpc);
    endfunction

    function automatic vec_t mv(input stim_t s, input logic pr, input logic rd,
                                input logic [31:0] rpc, input logic fi, input logic fe,
                                input logic [15:0] c);
        vec_t r;
        r.s = s; r.pred = pr; r.redir = rd; r.rpc = rpc; r.fif = fi; r.fie = fe; r.cnt = c;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        rst_n = s.rst_n; if_valid = s.if_valid; if_pc = s.if_pc;
        ex_valid = s.ex_valid; ex_branch = s.ex_branch; ex_jump = s.ex_jump;
        ex_taken = s.ex_taken; ex_pred_taken = s.ex_pred_taken;
        ex_pc = s.ex_pc; ex_target = s.ex_target;
    endtask

    task automatic model_edge();
        int  idx;
        bit  mis;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_tbl[i] = 1;
            m_busy = 0; m_rpc = 32'h0; m_cnt = 0;
        end else if (m_busy == 0) begin
            if (ex_valid && (ex_branch || ex_jump)) begin
                idx = int'(ex_pc[5:2]);
                if (ex_jump) begin
                    mis = !ex_pred_taken;
                end else begin
                    mis = (ex_taken != ex_pred_taken);
                    if (ex_taken) m_tbl[idx] = (m_tbl[idx] == 3) ? 3 : m_tbl[idx] + 1;
                    else          m_tbl[idx] = (m_tbl[idx] == 0) ? 0 : m_tbl[idx] - 1;
                end
                if (mis) begin
                    m_busy = 2;
                    m_rpc  = (ex_jump || ex_taken) ? ex_target : ex_pc + 32'd4;
                    m_cnt++;
                end
            end
        end else begin
            m_busy--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model_pre();
        chk("rnd pred_taken", 32'(pred_taken), 32'(if_valid && (m_tbl[if_pc[5:2]] >= 2)));
    endtask

    task automatic chk_model_post();
        chk("rnd redirect",    32'(redirect),    32'(m_busy == 2));
        chk("rnd flush_if_id", 32'(flush_if_id), 32'(m_busy > 0));
        chk("rnd flush_id_ex", 32'(flush_id_ex), 32'(m_busy == 2));
        chk("rnd redirect_pc", redirect_pc,      m_rpc);
        chk("rnd cnt16",       32'(mispredict_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
        chk("rnd cnt4_sat",    32'(sat_cnt),        32'((m_cnt > 15) ? 15 : m_cnt));
    endtask

    vec_t  vecs [17];
    stim_t s;
    stim_t mp;

    initial begin
        // Table trace after reset: idx0 01->10 (v0), idx15 01->00 (v3), v4/v5 ignored,
        // jumps leave idx0 alone, v10 idx0 10->01, v11/v12 jump-priority leaves idx1,
        // v14 is the recover cycle, v15 trains idx1 01->10.
        vecs[0]  = mv(st(1,1,0,1,0, 32'h100,      32'h80,   1, 32'h40),  0, 1, 32'h80,  1, 1, 16'd1);
        vecs[1]  = mv(idle_s(1, 32'h100),                                   1, 0, 32'h80,  1, 0, 16'd1);
        vecs[2]  = mv(idle_s(0, 32'h100),                                   0, 0, 32'h80,  0, 0, 16'd1);
        vecs[3]  = mv(st(1,1,0,0,1, 32'hFFFFFFFC, 32'h1234, 1, 32'hFC),  0, 1, 32'h0,   1, 1, 16'd2);
        vecs[4]  = mv(st(1,1,0,1,0, 32'h40,       32'h999,  1, 32'hFC),  0, 0, 32'h0,   1, 0, 16'd2);
        vecs[5]  = mv(st(1,0,1,0,0, 32'h40,       32'h500,  1, 32'h4),   0, 0, 32'h0,   0, 0, 16'd2);
        vecs[6]  = mv(st(1,0,1,0,0, 32'h200,      32'h300,  1, 32'h0),   1, 1, 32'h300, 1, 1, 16'd3);
        vecs[7]  = mv(idle_s(1, 32'h40),                                    1, 0, 32'h300, 1, 0, 16'd3);
        vecs[8]  = mv(idle_s(1, 32'h0),                                     1, 0, 32'h300, 0, 0, 16'd3);
        vecs[9]  = mv(st(1,0,1,0,1, 32'h204,      32'h700,  1, 32'h44),  0, 0, 32'h300, 0, 0, 16'd3);
        vecs[10] = mv(st(1,1,0,0,0, 32'h80,       32'h111,  1, 32'h100), 1, 0, 32'h300, 0, 0, 16'd3);
        vecs[11] = mv(st(1,1,1,1,1, 32'h44,       32'h222,  1, 32'h40),  0, 0, 32'h300, 0, 0, 16'd3);
        vecs[12] = mv(st(1,1,1,0,0, 32'h44,       32'h600,  1, 32'h44),  0, 1, 32'h600, 1, 1, 16'd4);
        vecs[13] = mv(idle_s(1, 32'h44),                                    0, 0, 32'h600, 1, 0, 16'd4);
        vecs[14] = mv(st(1,1,0,1,1, 32'h44,       32'h10,   1, 32'h44),  0, 0, 32'h600, 0, 0, 16'd4);
        vecs[15] = mv(st(1,1,0,1,1, 32'h44,       32'h10,   1, 32'h44),  0, 0, 32'h600, 0, 0, 16'd4);
        vecs[16] = mv(idle_s(1, 32'h44),                                    1, 0, 32'h600, 0, 0, 16'd4);

        // Reset and reset-state checks.
        s = idle_s(1, 32'h40);
        s.rst_n = 1'b0;
        drive(s);
        tick();
        tick();
        chk("reset redirect",    32'(redirect),       32'h0);
        chk("reset flush_if_id", 32'(flush_if_id),    32'h0);
        chk("reset flush_id_ex", 32'(flush_id_ex),    32'h0);
        chk("reset redirect_pc", redirect_pc,         32'h0);
        chk("reset cnt",         32'(mispredict_cnt), 32'h0);
        drive(idle_s(1, 32'h40));
        #1;
        chk("reset pred 0x40",   32'(pred_taken),     32'h0);
        tick();

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].s);
            #1;
            chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].pred));
            tick();
            chk($sformatf("v%0d redirect", i),    32'(redirect),       32'(vecs[i].redir));
            chk($sformatf("v%0d redirect_pc", i), redirect_pc,         vecs[i].rpc);
            chk($sformatf("v%0d flush_if_id", i), 32'(flush_if_id),    32'(vecs[i].fif));
            chk($sformatf("v%0d flush_id_ex", i), 32'(flush_id_ex),    32'(vecs[i].fie));
            chk($sformatf("v%0d cnt", i),         32'(mispredict_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d cnt4", i),        32'(sat_cnt),        32'(vecs[i].cnt));
        end

        // Repeated taken branch at 0x40: re-presentations during recovery are ignored.
        s = idle_s(1, 32'h40);
        s.rst_n = 1'b0;
        drive(s);
        tick();
        mp = st(1,1,0,1,0, 32'h40, 32'hA0, 1, 32'h40);
        drive(mp);
        #1;
        chk("seq pred 0x40 initial", 32'(pred_taken), 32'h0);
        tick();
        chk("seq first redirect", 32'(redirect), 32'h1);
        tick();
        chk("seq ignored in REDIRECT cnt", 32'(mispredict_cnt), 32'h1);
        tick();
        chk("seq ignored in RECOVER cnt", 32'(mispredict_cnt), 32'h1);
        chk("seq back to idle flush",     32'(flush_if_id),    32'h0);
        tick();
        chk("seq second accepted cnt",      32'(mispredict_cnt), 32'h2);
        chk("seq second accepted redirect", 32'(redirect),       32'h1);
        drive(idle_s(1, 32'h40));
        #1;
        chk("seq pred 0x40 trained", 32'(pred_taken), 32'h1);
        tick();
        tick();

        // Reset during REDIRECT, with a coincident mispredicting resolve.
        drive(mp);
        tick();
        chk("rstR redirect before", 32'(redirect), 32'h1);
        s = mp;
        s.rst_n = 1'b0;
        drive(s);
        tick();
        chk("rstR redirect",    32'(redirect),       32'h0);
        chk("rstR flush_if_id", 32'(flush_if_id),    32'h0);
        chk("rstR flush_id_ex", 32'(flush_id_ex),    32'h0);
        chk("rstR redirect_pc", redirect_pc,         32'h0);
        chk("rstR cnt",         32'(mispredict_cnt), 32'h0);
        drive(idle_s(1, 32'h40));
        #1;
        chk("rstR pred table reset", 32'(pred_taken), 32'h0);
        tick();
        chk("rstR no later flush", 32'(flush_if_id), 32'h0);
        chk("rstR no later redir", 32'(redirect),    32'h0);

        // Reset during RECOVER.
        drive(mp);
        tick();
        drive(idle_s(0, 32'h0));
        tick();
        chk("rstC recover flush_if_id", 32'(flush_if_id), 32'h1);
        chk("rstC recover flush_id_ex", 32'(flush_id_ex), 32'h0);
        s = idle_s(0, 32'h0);
        s.rst_n = 1'b0;
        drive(s);
        tick();
        chk("rstC flush_if_id", 32'(flush_if_id), 32'h0);
        drive(idle_s(0, 32'h0));
        tick();
        chk("rstC no later flush", 32'(flush_if_id), 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            s.rst_n         = ($urandom_range(0, 199) != 0);
            s.if_valid      = 1'($urandom_range(0, 3) != 0);
            s.if_pc         = $urandom;
            s.ex_valid      = 1'($urandom_range(0, 9) < 7);
            s.ex_branch     = 1'($urandom_range(0, 3) != 0);
            s.ex_jump       = 1'($urandom_range(0, 4) == 0);
            s.ex_taken      = 1'($urandom_range(0, 1));
            s.ex_pred_taken = 1'($urandom_range(0, 1));
            s.ex_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
            s.ex_target     = $urandom;
            drive(s);
            #1;
            chk_model_pre();
            tick();
            chk_model_post();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
